// File: rtl/hgame_match_ctrl.sv
// hgame_match_ctrl: three-player match sequencer (lock gather, round fire, scoring, result hold).
// Define HGAME_DRAW_LIMIT_EN to end a match after MAX_DRAWS consecutive drawn rounds.
module hgame_match_ctrl #(
   parameter int WIN_POINTS  = 3,
   parameter int SW          = 2,
   parameter int SHOW_CYCLES = 4,
   parameter int RES_TIMEOUT = 8,
   parameter int MAX_DRAWS   = 5
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic          lock_a,
   input  logic          lock_b,
   input  logic          lock_c,
   output logic          round_go,
   input  logic          res_valid,
   input  logic [2:0]    res_win,
   output logic          show,
   output logic [SW-1:0] score_a,
   output logic [SW-1:0] score_b,
   output logic [SW-1:0] score_c,
   output logic [7:0]    round_cnt,
   output logic          busy,
   output logic          match_done,
   output logic [2:0]    match_winner
);
   typedef enum logic [2:0] {IDLE, WAIT_LOCK, GO, WAIT_RES, SHOW, DONE} state_t;
   localparam int TW = $clog2(RES_TIMEOUT + 1);
   localparam int CW = $clog2(SHOW_CYCLES + 1);
   localparam logic [SW-1:0] WP = SW'(WIN_POINTS);
   state_t        state;
   logic [2:0]    locked, all_lock, res, at_win;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] scnt;
   logic          capture;
`ifdef HGAME_DRAW_LIMIT_EN
   localparam int DW = $clog2(MAX_DRAWS + 1);
   logic [DW-1:0] draws;
`endif
   // A silent core is scored as a draw once the timeout window closes.
   always_comb begin
      all_lock = locked | {lock_a, lock_b, lock_c};
      res      = res_valid ? res_win : 3'b000;
      capture  = state == WAIT_RES && (res_valid || tcnt == TW'(RES_TIMEOUT - 1));
      at_win   = {score_a == WP, score_b == WP, score_c == WP};
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         locked       <= '0;
         tcnt         <= '0;
         scnt         <= '0;
         round_go     <= 1'b0;
         show         <= 1'b0;
         busy         <= 1'b0;
         match_done   <= 1'b0;
         match_winner <= '0;
         score_a      <= '0;
         score_b      <= '0;
         score_c      <= '0;
         round_cnt    <= '0;
`ifdef HGAME_DRAW_LIMIT_EN
         draws        <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state        <= WAIT_LOCK;
               busy         <= 1'b1;
               match_done   <= 1'b0;
               match_winner <= '0;
               score_a      <= '0;
               score_b      <= '0;
               score_c      <= '0;
               round_cnt    <= '0;
               locked       <= '0;
`ifdef HGAME_DRAW_LIMIT_EN
               draws        <= '0;
`endif
            end
            WAIT_LOCK: begin
               locked <= all_lock;
               if (&all_lock) begin
                  state    <= GO;
                  round_go <= 1'b1;
               end
            end
            GO: begin
               round_go <= 1'b0;
               locked   <= '0;
               tcnt     <= '0;
               state    <= WAIT_RES;
            end
            WAIT_RES: if (capture) begin
               score_a   <= (res[2] && score_a != WP) ? score_a + SW'(1) : score_a;
               score_b   <= (res[1] && score_b != WP) ? score_b + SW'(1) : score_b;
               score_c   <= (res[0] && score_c != WP) ? score_c + SW'(1) : score_c;
               round_cnt <= round_cnt + 8'(round_cnt != 8'hFF);
`ifdef HGAME_DRAW_LIMIT_EN
               draws     <= (res != 3'b000) ? '0 : (draws == DW'(MAX_DRAWS)) ? draws : draws + DW'(1);
`endif
               show      <= 1'b1;
               scnt      <= '0;
               state     <= SHOW;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
            SHOW: if (scnt == CW'(SHOW_CYCLES - 1)) begin
               show <= 1'b0;
               if (|at_win) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  match_done   <= 1'b1;
                  match_winner <= at_win;
               end
`ifdef HGAME_DRAW_LIMIT_EN
               else if (draws == DW'(MAX_DRAWS)) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  match_done   <= 1'b1;
                  match_winner <= '0;
               end
`endif
               else state <= WAIT_LOCK;
            end else begin
               scnt <= scnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hgame_match_ctrl.sv
// tb_hgame_match_ctrl: directed and randomized checks of hgame_match_ctrl against a round-level model.
module tb_hgame_match_ctrl;
   localparam int WIN = 3, SW = 2, SHOWC = 4, TO = 8, MAXD = 5;
   logic CLK = 0, RST = 1, start = 0, lock_a = 0, lock_b = 0, lock_c = 0, res_valid = 0;
   logic [2:0] res_win = 0;
   logic round_go, show, busy, match_done;
   logic [SW-1:0] score_a, score_b, score_c;
   logic [7:0] round_cnt;
   logic [2:0] match_winner;
   int total = 0, passed = 0;
   bit chk_en = 0;
   int m_sa = 0, m_sb = 0, m_sc = 0, m_rounds = 0, m_draws = 0, m_age = 0, m_show = 0;
   bit m_active = 0, m_done = 0, m_go = 0, m_wait = 0;
   logic [2:0] m_locked = 0, m_winner = 0, m_mask, locks;
   logic [20:0] act_v, exp_v;

   always #5 CLK = ~CLK;

   hgame_match_ctrl #(.WIN_POINTS(WIN), .SW(SW), .SHOW_CYCLES(SHOWC), .RES_TIMEOUT(TO), .MAX_DRAWS(MAXD)) dut (
      .CLK(CLK), .RST(RST), .start(start), .lock_a(lock_a), .lock_b(lock_b), .lock_c(lock_c),
      .round_go(round_go), .res_valid(res_valid), .res_win(res_win), .show(show),
      .score_a(score_a), .score_b(score_b), .score_c(score_c), .round_cnt(round_cnt),
      .busy(busy), .match_done(match_done), .match_winner(match_winner));

   assign locks  = {lock_a, lock_b, lock_c};
   assign m_mask = {m_sa == WIN, m_sb == WIN, m_sc == WIN};
   assign act_v  = {round_go, show, score_a, score_b, score_c, round_cnt, busy, match_done, match_winner};
   assign exp_v  = {m_go, m_show > 0, SW'(m_sa), SW'(m_sb), SW'(m_sc), 8'(m_rounds), m_active, m_done, m_winner};

   // Round-level model: a match is active, a round fires, waits for a result, then shows it.
   always @(posedge CLK) begin
      if (RST) begin
         m_sa <= 0; m_sb <= 0; m_sc <= 0; m_rounds <= 0; m_draws <= 0; m_age <= 0; m_show <= 0;
         m_active <= 0; m_done <= 0; m_go <= 0; m_wait <= 0; m_locked <= 0; m_winner <= 0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1; m_done <= 0; m_winner <= 0; m_locked <= 0;
            m_sa <= 0; m_sb <= 0; m_sc <= 0; m_rounds <= 0; m_draws <= 0;
         end
      end else if (m_go) begin
         m_go <= 0; m_wait <= 1; m_age <= 0;
      end else if (m_wait) begin
         if (res_valid || m_age == TO - 1) begin
            m_wait <= 0;
            m_show <= SHOWC;
            if (res_valid && res_win[2] && m_sa < WIN) m_sa <= m_sa + 1;
            if (res_valid && res_win[1] && m_sb < WIN) m_sb <= m_sb + 1;
            if (res_valid && res_win[0] && m_sc < WIN) m_sc <= m_sc + 1;
            if (m_rounds < 255) m_rounds <= m_rounds + 1;
            m_draws <= (res_valid && res_win != 0) ? 0 : m_draws + 1;
         end else m_age <= m_age + 1;
      end else if (m_show > 0) begin
         m_show <= m_show - 1;
         if (m_show == 1) begin
            if (m_mask != 0) begin
               m_active <= 0; m_done <= 1; m_winner <= m_mask;
            end
`ifdef HGAME_DRAW_LIMIT_EN
            else if (m_draws >= MAXD) begin
               m_active <= 0; m_done <= 1; m_winner <= 0;
            end
`endif
         end
      end else if ((m_locked | locks) == 3'b111) begin
         m_go <= 1; m_locked <= 0;
      end else m_locked <= m_locked | locks;
   end

   always @(negedge CLK) if (chk_en) begin
      total++;
      if (act_v === exp_v) passed++;
      else $display("FAIL model_cycle t=%0t got %h expected %h", $time, act_v, exp_v);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic cyc(input logic [2:0] l, input logic rv, input logic [2:0] rw, input logic st);
      {lock_a, lock_b, lock_c} = l; res_valid = rv; res_win = rw; start = st;
      tick(1);
      {lock_a, lock_b, lock_c} = 0; res_valid = 0; res_win = 0; start = 0;
   endtask

   task automatic play(input logic rv, input logic [2:0] rw);
      cyc(3'b111, 0, 0, 0);
      tick(1);
      if (rv) cyc(0, 1, rw, 0); else tick(TO);
      tick(SHOWC);
   endtask

   initial begin
      int n;
      tick(2);
      chk_en = 1;
      RST = 0;
      chk("reset_outputs", {round_go, show, busy, match_done, match_winner, round_cnt}, 0);
      chk("reset_score_a", score_a, 0);
      cyc(0, 0, 0, 1);
      chk("start_busy", busy, 1);
      cyc(3'b100, 0, 0, 0);
      cyc(3'b010, 0, 0, 0);
      chk("no_go_before_c", round_go, 0);
      cyc(3'b001, 0, 0, 0);
      chk("go_after_lock_c", round_go, 1);
      tick(1);
      chk("go_single_pulse", round_go, 0);
      cyc(0, 1, 3'b100, 0);
      chk("score_a_1", score_a, 1);
      chk("show_on_capture", show, 1);
      tick(SHOWC);
      play(1, 3'b100);
      chk("score_a_2", score_a, 2);
      chk("not_done_at_2", match_done, 0);
      play(1, 3'b100);
      chk("score_a_3", score_a, 3);
      chk("done_a", match_done, 1);
      chk("winner_a", match_winner, 3'b100);
      chk("rounds_3", round_cnt, 3);
      chk("idle_busy", busy, 0);
      cyc(0, 0, 0, 1);
      cyc(3'b111, 0, 0, 0);
      tick(1);
      tick(TO - 1);
      chk("no_early_timeout", show, 0);
      tick(1);
      chk("timeout_show", show, 1);
      chk("timeout_scores", {score_a, score_b, score_c}, 0);
      chk("timeout_round", round_cnt, 1);
      n = 0;
      for (int i = 0; i < 6; i++) begin n += int'(show); tick(1); end
      chk("show_len", n, SHOWC);
      cyc(0, 0, 0, 1);
      chk("start_ignored", {busy, round_cnt}, {1'b1, 8'd1});
      cyc(3'b111, 0, 0, 0);
      tick(1);
      RST = 1;
      tick(2);
      RST = 0;
      chk("rst_outputs", {round_go, show, busy, match_done, match_winner, round_cnt, score_a, score_b, score_c}, 0);
      tick(3);
      chk("idle_until_start", busy, 0);
      cyc(0, 0, 0, 1);
      play(1, 3'b110);
      play(1, 3'b110);
      chk("tie_2_2", {score_a, score_b, score_c}, {2'd2, 2'd2, 2'd0});
      play(1, 3'b110);
      chk("tie_winner", match_winner, 3'b110);
      chk("tie_scores", {score_a, score_b}, {2'd3, 2'd3});
      chk("tie_done", match_done, 1);
      cyc(0, 0, 0, 1);
      repeat (5) play(1, 3'b000);
`ifdef HGAME_DRAW_LIMIT_EN
      chk("draw_limit_done", match_done, 1);
      chk("draw_limit_winner", match_winner, 0);
      chk("draw_limit_rounds", round_cnt, 5);
`else
      chk("draws_continue", {busy, match_done}, 2'b10);
      cyc(3'b111, 0, 0, 0);
      chk("sixth_round_go", round_go, 1);
`endif
      for (int i = 0; i < 3000; i++) begin
         RST       = ($urandom_range(499) == 0);
         start     = ($urandom_range(19) == 0);
         lock_a    = ($urandom_range(2) == 0);
         lock_b    = ($urandom_range(2) == 0);
         lock_c    = ($urandom_range(2) == 0);
         res_valid = ($urandom_range(5) == 0);
         res_win   = 3'($urandom_range(7));
         tick(1);
      end
      {RST, start, lock_a, lock_b, lock_c, res_valid, res_win} = 0;
      tick(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
